// File: rtl/fan_edge_tag_gen.sv
// fan_edge_tag_gen
// Producer side of the forwarding-adder reduction network. Takes a stream of
// row-index beats (one row id per product lane) and emits the same beats with
// per-lane {end,start} group tags and a prefix-forced lane mask, so the adder
// tree knows where each row group begins and ends, even across beats.
//
// The start bits of a beat are known when it is accepted (they only need the
// previous beat's last valid row). The end bit of the last valid lane depends
// on the next nonempty beat, so every non-final beat waits in the hold
// register H until its successor arrives. Only then is it finalized into the
// output register O.

module fan_edge_tag_gen #(
    parameter int NUM_IN = 4,
    parameter int DW_ROW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW_ROW*NUM_IN-1:0] in_row,
    input  logic [NUM_IN-1:0]        in_mask,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW_ROW*NUM_IN-1:0] out_row,
    output logic [NUM_IN-1:0]        out_mask,
    output logic [2*NUM_IN-1:0]      out_tag,
    output logic                     out_last
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Lanes at and above the first cleared mask bit are treated as masked.
    function automatic logic [NUM_IN-1:0] prefixMask(input logic [NUM_IN-1:0] mask);
        logic [NUM_IN-1:0] result;
        logic              run;
        result = '0;
        run    = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            run       = run & mask[i];
            result[i] = run;
        end
        return result;
    endfunction

    // Group-start bits of one beat. Lane 0 compares against the last valid row
    // of the previous beat unless this beat opens a new packet.
    function automatic logic [NUM_IN-1:0] startBits(
        input logic [NUM_IN-1:0][DW_ROW-1:0] rows,
        input logic [NUM_IN-1:0]             mask,
        input logic                          first,
        input logic [DW_ROW-1:0]             prev
    );
        logic [NUM_IN-1:0] result;
        result    = '0;
        result[0] = mask[0] & (first | (rows[0] != prev));
        for (int i = 1; i < NUM_IN; i++) begin
            result[i] = mask[i] & (rows[i] != rows[i-1]);
        end
        return result;
    endfunction

    // Row id of the highest valid lane; only meaningful for a nonempty beat.
    function automatic logic [DW_ROW-1:0] lastValidRow(
        input logic [NUM_IN-1:0][DW_ROW-1:0] rows,
        input logic [NUM_IN-1:0]             mask
    );
        logic [DW_ROW-1:0] result;
        result = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (mask[i]) begin
                result = rows[i];
            end
        end
        return result;
    endfunction

    // Full tag vector of a beat. Interior lanes compare with their right-hand
    // neighbour; the last valid lane closes its group at packet end or when the
    // following beat starts on a different row.
    function automatic logic [2*NUM_IN-1:0] buildTag(
        input logic [NUM_IN-1:0][DW_ROW-1:0] rows,
        input logic [NUM_IN-1:0]             mask,
        input logic [NUM_IN-1:0]             starts,
        input logic                          isEnd,
        input logic [DW_ROW-1:0]             nextRow
    );
        logic [2*NUM_IN-1:0]         tag;
        logic [NUM_IN:0][DW_ROW-1:0] rowExt;
        logic [NUM_IN:0]             maskExt;
        logic                        endBit;
        tag     = '0;
        rowExt  = {nextRow, rows};
        maskExt = {1'b0, mask};
        for (int i = 0; i < NUM_IN; i++) begin
            if (maskExt[i+1]) begin
                endBit = rowExt[i] != rowExt[i+1];
            end else begin
                endBit = isEnd | (rowExt[i] != nextRow);
            end
            tag[2*i]   = mask[i] & starts[i];
            tag[2*i+1] = mask[i] & endBit;
        end
        return tag;
    endfunction

    state_t r_state;
    state_t w_nextState;

    logic                     r_first;
    logic [DW_ROW-1:0]        r_prev;

    logic [DW_ROW*NUM_IN-1:0] r_hRow;
    logic [NUM_IN-1:0]        r_hMask;
    logic [NUM_IN-1:0]        r_hStart;

    logic                     r_oValid;
    logic [DW_ROW*NUM_IN-1:0] r_oRow;
    logic [NUM_IN-1:0]        r_oMask;
    logic [2*NUM_IN-1:0]      r_oTag;
    logic                     r_oLast;

    logic [NUM_IN-1:0]        w_effMask;
    logic                     w_nonEmpty;
    logic [NUM_IN-1:0]        w_inStart;
    logic [DW_ROW-1:0]        w_inLastRow;
    logic [DW_ROW-1:0]        w_inRow0;
    logic                     w_oFree;
    logic                     w_accept;
    logic [2*NUM_IN-1:0]      w_tagFromIn;
    logic [2*NUM_IN-1:0]      w_tagFromH;

    logic                     w_loadH;
    logic                     w_loadO;
    logic                     w_oFromIn;
    logic                     w_oEnd;
    logic                     w_oLast;

    assign w_effMask   = prefixMask(in_mask);
    assign w_nonEmpty  = w_effMask[0];
    assign w_inStart   = startBits(in_row, w_effMask, r_first, r_prev);
    assign w_inLastRow = lastValidRow(in_row, w_effMask);
    assign w_inRow0    = in_row[DW_ROW-1:0];

    assign w_oFree  = !r_oValid || out_ready;
    assign in_ready = (r_state != ST_DRAIN) && w_oFree;
    assign w_accept = in_valid && in_ready;

    assign w_tagFromIn = buildTag(in_row, w_effMask, w_inStart, 1'b1, '0);
    assign w_tagFromH  = buildTag(r_hRow, r_hMask, r_hStart, w_oEnd, w_inRow0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: H fills on a non-final beat and empties at packet end.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept && !in_last && w_nonEmpty) begin
                    w_nextState = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_accept && in_last) begin
                    w_nextState = w_nonEmpty ? ST_DRAIN : ST_EMPTY;
                end
            end
            ST_DRAIN: begin
                if (w_oFree) begin
                    w_nextState = ST_EMPTY;
                end
            end
            default: w_nextState = ST_EMPTY;
        endcase
    end

    // Datapath controls: which register loads, and how the outgoing beat is closed.
    always_comb begin
        w_loadH   = 1'b0;
        w_loadO   = 1'b0;
        w_oFromIn = 1'b0;
        w_oEnd    = 1'b0;
        w_oLast   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    if (in_last) begin
                        w_loadO   = 1'b1;
                        w_oFromIn = 1'b1;
                        w_oLast   = 1'b1;
                    end else if (w_nonEmpty) begin
                        w_loadH = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_accept) begin
                    if (w_nonEmpty) begin
                        w_loadO = 1'b1;
                        w_loadH = 1'b1;
                    end else if (in_last) begin
                        w_loadO = 1'b1;
                        w_oEnd  = 1'b1;
                        w_oLast = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_oFree) begin
                    w_loadO = 1'b1;
                    w_oEnd  = 1'b1;
                    w_oLast = 1'b1;
                end
            end
            default: begin
                w_loadO = 1'b0;
            end
        endcase
    end

    // Track the previous beat's last valid row and whether the next beat opens a packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first <= 1'b1;
            r_prev  <= '0;
        end else if (w_accept) begin
            if (w_nonEmpty) begin
                r_prev <= w_inLastRow;
            end
            if (in_last) begin
                r_first <= 1'b1;
            end else if (w_nonEmpty) begin
                r_first <= 1'b0;
            end
        end
    end

    // Hold register: one beat with its start bits resolved, waiting for its successor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hRow   <= '0;
            r_hMask  <= '0;
            r_hStart <= '0;
        end else if (w_loadH) begin
            r_hRow   <= in_row;
            r_hMask  <= w_effMask;
            r_hStart <= w_inStart;
        end
    end

    // Output register: fully tagged beat, held steady until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oValid <= 1'b0;
            r_oRow   <= '0;
            r_oMask  <= '0;
            r_oTag   <= '0;
            r_oLast  <= 1'b0;
        end else if (w_loadO) begin
            r_oValid <= 1'b1;
            r_oRow   <= w_oFromIn ? in_row : r_hRow;
            r_oMask  <= w_oFromIn ? w_effMask : r_hMask;
            r_oTag   <= w_oFromIn ? w_tagFromIn : w_tagFromH;
            r_oLast  <= w_oLast;
        end else if (out_ready) begin
            r_oValid <= 1'b0;
        end
    end

    assign out_valid = r_oValid;
    assign out_row   = r_oRow;
    assign out_mask  = r_oMask;
    assign out_tag   = r_oTag;
    assign out_last  = r_oLast;

endmodule

// File: tb/tb_fan_edge_tag_gen.sv
// tb_fan_edge_tag_gen
// Directed bench for fan_edge_tag_gen with NUM_IN=4, DW_ROW=8. Expected beats
// are written as constants and queued when their stimulus is driven; a
// monitor pops and compares them whenever the DUT hands a beat downstream.

module tb_fan_edge_tag_gen;

    localparam int NUM_IN = 4;
    localparam int DW_ROW = 8;

    typedef struct packed {
        logic [31:0] row;
        logic [3:0]  mask;
        logic [7:0]  tag;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_row;
    logic [3:0]  in_mask;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_row;
    logic [3:0]  out_mask;
    logic [7:0]  out_tag;
    logic        out_last;

    beat_t expQ[$];
    int    passCount = 0;
    int    failCount = 0;
    int    checkCount = 0;

    fan_edge_tag_gen #(
        .NUM_IN (NUM_IN),
        .DW_ROW (DW_ROW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .in_mask   (in_mask),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_mask  (out_mask),
        .out_tag   (out_tag),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rowsOf(input logic [7:0] r0, input logic [7:0] r1,
                                           input logic [7:0] r2, input logic [7:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    function automatic logic [7:0] tagsOf(input logic [1:0] t0, input logic [1:0] t1,
                                          input logic [1:0] t2, input logic [1:0] t3);
        return {t3, t2, t1, t0};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    task automatic expectBeat(input logic [31:0] row, input logic [3:0] mask,
                              input logic [7:0] tag, input logic last);
        beat_t b;
        b.row  = row;
        b.mask = mask;
        b.tag  = tag;
        b.last = last;
        expQ.push_back(b);
    endtask

    // Present one beat and hold it until the DUT accepts it (bounded wait).
    task automatic applyStimulus(input logic [31:0] rows, input logic [3:0] mask,
                                 input logic last);
        int waitCycles = 0;
        in_row   = rows;
        in_mask  = mask;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waitCycles < 50) begin
            waitCycles++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_mask  = '0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every beat handed downstream must match the queue head.
    always @(negedge clk) begin : monitor
        beat_t b;
        if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_beat", 64'(out_valid), 64'd0);
            end else begin
                b = expQ.pop_front();
                checkOutput("out_tag", 64'(out_tag), 64'(b.tag));
                checkOutput("out_row_mask_last", 64'({out_row, out_mask, out_last}),
                            64'({b.row, b.mask, b.last}));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lowCount;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        in_mask   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_row", 64'(out_row), 64'd0);
        checkOutput("rst_out_mask", 64'(out_mask), 64'd0);
        checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
        checkOutput("rst_out_last", 64'(out_last), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] single last beat");
        expectBeat(rowsOf(0, 0, 1, 2), 4'hF, tagsOf(2'b01, 2'b10, 2'b11, 2'b11), 1'b1);
        applyStimulus(rowsOf(0, 0, 1, 2), 4'hF, 1'b1);
        checkOutput("t1_latency", 64'(out_valid), 64'd1);
        idleCycles(2);

        $display("[TB] two-beat packet with drain");
        expectBeat(rowsOf(0, 0, 1, 1), 4'hF, tagsOf(2'b01, 2'b10, 2'b01, 2'b00), 1'b0);
        expectBeat(rowsOf(1, 2, 2, 2), 4'hF, tagsOf(2'b10, 2'b01, 2'b00, 2'b10), 1'b1);
        applyStimulus(rowsOf(0, 0, 1, 1), 4'hF, 1'b0);
        checkOutput("t2_held_not_emitted", 64'(out_valid), 64'd0);
        applyStimulus(rowsOf(1, 2, 2, 2), 4'hF, 1'b1);
        checkOutput("t2_first_emitted", 64'(out_valid), 64'd1);
        lowCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!in_ready) lowCount++;
        end
        checkOutput("t2_drain_ready_low", 64'(lowCount), 64'd1);
        idleCycles(2);

        $display("[TB] backpressure with three beats pending");
        out_ready = 1'b0;
        expectBeat(rowsOf(1, 1, 2, 2), 4'hF, tagsOf(2'b01, 2'b10, 2'b01, 2'b00), 1'b0);
        expectBeat(rowsOf(2, 3, 3, 3), 4'hF, tagsOf(2'b10, 2'b01, 2'b00, 2'b00), 1'b0);
        expectBeat(rowsOf(3, 4, 4, 4), 4'hF, tagsOf(2'b10, 2'b01, 2'b00, 2'b10), 1'b1);
        applyStimulus(rowsOf(1, 1, 2, 2), 4'hF, 1'b0);
        applyStimulus(rowsOf(2, 3, 3, 3), 4'hF, 1'b0);
        in_row   = rowsOf(3, 4, 4, 4);
        in_mask  = 4'hF;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t3_stall_in_ready", 64'(in_ready), 64'd0);
            checkOutput("t3_stall_valid", 64'(out_valid), 64'd1);
            checkOutput("t3_stall_tag", 64'(out_tag),
                        64'(tagsOf(2'b01, 2'b10, 2'b01, 2'b00)));
            checkOutput("t3_stall_row", 64'(out_row), 64'(rowsOf(1, 1, 2, 2)));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(rowsOf(3, 4, 4, 4), 4'hF, 1'b1);
        idleCycles(4);

        $display("[TB] mask forcing");
        expectBeat(rowsOf(3, 3, 7, 9), 4'b0011, tagsOf(2'b01, 2'b10, 2'b00, 2'b00), 1'b1);
        applyStimulus(rowsOf(3, 3, 7, 9), 4'b0011, 1'b1);
        expectBeat(rowsOf(3, 3, 7, 9), 4'b0001, tagsOf(2'b11, 2'b00, 2'b00, 2'b00), 1'b1);
        applyStimulus(rowsOf(3, 3, 7, 9), 4'b0101, 1'b1);
        expectBeat(rowsOf(6, 6, 6, 6), 4'b0000, 8'h00, 1'b1);
        applyStimulus(rowsOf(6, 6, 6, 6), 4'b0000, 1'b1);
        idleCycles(3);

        $display("[TB] held beat closed by empty last beat");
        expectBeat(rowsOf(5, 5, 5, 5), 4'hF, tagsOf(2'b01, 2'b00, 2'b00, 2'b10), 1'b1);
        applyStimulus(rowsOf(5, 5, 5, 5), 4'hF, 1'b0);
        applyStimulus(rowsOf(1, 2, 3, 4), 4'b0000, 1'b1);
        idleCycles(4);
        checkOutput("t5_no_extra_beat", 64'(expQ.size()), 64'd0);

        $display("[TB] reset while holding");
        out_ready = 1'b0;
        applyStimulus(rowsOf(4, 4, 4, 5), 4'hF, 1'b0);
        applyStimulus(rowsOf(5, 5, 5, 5), 4'hF, 1'b0);
        checkOutput("t6_pre_reset_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_reset_valid", 64'(out_valid), 64'd0);
        checkOutput("t6_reset_tag", 64'(out_tag), 64'd0);
        checkOutput("t6_reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        expectBeat(rowsOf(5, 6, 6, 6), 4'hF, tagsOf(2'b11, 2'b01, 2'b00, 2'b10), 1'b1);
        applyStimulus(rowsOf(5, 6, 6, 6), 4'hF, 1'b1);
        idleCycles(3);

        $display("[TB] empty non-last beat dropped while holding");
        expectBeat(rowsOf(7, 7, 8, 8), 4'hF, tagsOf(2'b01, 2'b10, 2'b01, 2'b00), 1'b0);
        expectBeat(rowsOf(8, 9, 9, 9), 4'hF, tagsOf(2'b10, 2'b01, 2'b00, 2'b10), 1'b1);
        applyStimulus(rowsOf(7, 7, 8, 8), 4'hF, 1'b0);
        applyStimulus(rowsOf(2, 2, 2, 2), 4'b0000, 1'b0);
        checkOutput("t7_still_held", 64'(out_valid), 64'd0);
        applyStimulus(rowsOf(8, 9, 9, 9), 4'hF, 1'b1);
        idleCycles(5);
        checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
